// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register sequencer.
// States, command-byte layout and default timing values.
package spi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_SETUP = 3'd1;
  localparam state_t S_CMD   = 3'd2;
  localparam state_t S_DATA  = 3'd3;
  localparam state_t S_RESP  = 3'd4;
  localparam state_t S_GAP   = 3'd5;

  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_ADDR_HI = 1;
  localparam int CMD_ADDR_LO = 0;

  localparam int unsigned SETUP_CYC_DEF   = 2;
  localparam int unsigned GAP_CYC_DEF     = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 1023;

  // Command byte: write flag on top, start register in the low bits.
  function automatic logic [7:0] cmd_byte(
    input logic       wr,
    input logic [1:0] addr
  );
    logic [7:0] b;
    b = '0;
    b[CMD_WR_BIT] = wr;
    b[CMD_ADDR_HI:CMD_ADDR_LO] = addr;
    return b;
  endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter for the SPI register sequencer.
// Contended requests go to the index that did not win last.
module spi_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       last_grant
);

  // Pick a single winner from the current requests.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11)
      grant = last_grant ? 2'b01 : 2'b10;
    else if (req[0])
      grant = 2'b01;
    else if (req[1])
      grant = 2'b10;
  end

  // Remember the winner; reset value lets req0 win first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= 1'b1;
    else if (advance && (|req))
      last_grant <= grant[1];
  end

endmodule

// File: rtl/spi_reg_sequencer.sv
// SPI register sequencer: arbitrates two requesters, runs cmd+data bytes.
// Optional per-byte m_done timeout under macro SPI_SEQ_TIMEOUT_EN.
module spi_reg_sequencer
  import spi_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = SETUP_CYC_DEF,
  parameter int unsigned GAP_CYC     = GAP_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [1:0]  req0_addr,
  input  logic [1:0]  req0_len,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [1:0]  req1_addr,
  input  logic [1:0]  req1_len,
  input  logic [31:0] req1_wdata,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        ss_n,
  output logic        m_start,
  output logic [7:0]  m_tx_data,
  input  logic        m_done,
  input  logic [7:0]  m_rx_data
);

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  k;
  logic [1:0]  nk;
  logic        wr;
  logic [1:0]  addr;
  logic [1:0]  len;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        id;
  logic [1:0]  grant;
  logic        last_grant;
  logic        sel;

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [15:0] tcnt;
  logic        err;
`endif

  assign nk  = k + 2'd1;
  assign sel = grant[1];

  spi_rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        ({req1_valid, req0_valid}),
    .advance    (state == S_IDLE),
    .grant      (grant),
    .last_grant (last_grant)
  );

`ifndef SPI_SEQ_TIMEOUT_EN
  assign rsp_err = 1'b0;
`endif

  // Main sequencer: grant, setup delay, byte loop, response, gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      k          <= '0;
      wr         <= 1'b0;
      addr       <= '0;
      len        <= '0;
      wdata      <= '0;
      rdata      <= '0;
      id         <= 1'b0;
      ss_n       <= 1'b1;
      m_start    <= 1'b0;
      m_tx_data  <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_rdata  <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
      tcnt       <= '0;
      err        <= 1'b0;
      rsp_err    <= 1'b0;
`endif
    end else begin
      m_start    <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp_valid  <= 1'b0;
      unique case (1'b1)
        state == S_IDLE: begin
          if (|grant) begin
            req0_ready <= grant[0];
            req1_ready <= grant[1];
            id    <= sel;
            wr    <= sel ? req1_write : req0_write;
            addr  <= sel ? req1_addr  : req0_addr;
            len   <= sel ? req1_len   : req0_len;
            wdata <= sel ? req1_wdata : req0_wdata;
            rdata <= '0;
            ss_n  <= 1'b0;
            cnt   <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
            err   <= 1'b0;
`endif
            state <= S_SETUP;
          end
        end
        state == S_SETUP: begin
          if (cnt >= 16'(SETUP_CYC - 1)) begin
            m_start   <= 1'b1;
            m_tx_data <= cmd_byte(wr, addr);
`ifdef SPI_SEQ_TIMEOUT_EN
            tcnt      <= '0;
`endif
            state     <= S_CMD;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        state == S_CMD || state == S_DATA: begin
          if (m_done) begin
`ifdef SPI_SEQ_TIMEOUT_EN
            tcnt <= '0;
`endif
            if (state == S_CMD) begin
              k         <= '0;
              m_start   <= 1'b1;
              m_tx_data <= wr ? wdata[7:0] : 8'h00;
              state     <= S_DATA;
            end else begin
              if (!wr)
                rdata[{k, 3'b000} +: 8] <= m_rx_data;
              if (k == len) begin
                ss_n  <= 1'b1;
                state <= S_RESP;
              end else begin
                k         <= nk;
                m_start   <= 1'b1;
                m_tx_data <= wr ? wdata[{nk, 3'b000} +: 8] : 8'h00;
              end
            end
          end
`ifdef SPI_SEQ_TIMEOUT_EN
          else if (tcnt >= 16'(TIMEOUT_CYC - 1)) begin
            ss_n  <= 1'b1;
            err   <= 1'b1;
            rdata <= '0;
            state <= S_RESP;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
`endif
        end
        state == S_RESP: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id;
          rsp_rdata <= rdata;
`ifdef SPI_SEQ_TIMEOUT_EN
          rsp_err   <= err;
`endif
          cnt       <= '0;
          state     <= S_GAP;
        end
        state == S_GAP: begin
          if (cnt >= 16'(GAP_CYC - 1))
            state <= S_IDLE;
          else
            cnt <= cnt + 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Self-checking bench for spi_reg_sequencer with a behavioural SPI slave.
// Timeout scenario runs only when SPI_SEQ_TIMEOUT_EN is defined.
module tb_spi_reg_sequencer;

  localparam int unsigned SETUP = 2;
  localparam int unsigned GAP   = 4;
  localparam int unsigned TMO   = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 0, req0_write = 0;
  logic [1:0]  req0_addr = 0, req0_len = 0;
  logic [31:0] req0_wdata = 0;
  logic        req1_valid = 0, req1_write = 0;
  logic [1:0]  req1_addr = 0, req1_len = 0;
  logic [31:0] req1_wdata = 0;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ss_n, m_start;
  logic [7:0]  m_tx_data;
  logic        m_done = 1'b0;
  logic [7:0]  m_rx_data = 8'h00;

  int tests = 0;
  int fails = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_fixed[$];
  int  cd = 0;
  bit  hang = 0;
  bit  stray_req = 0;

  spi_reg_sequencer #(
    .SETUP_CYC   (SETUP),
    .GAP_CYC     (GAP),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_len   (req0_len),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_len   (req1_len),
    .req1_wdata (req1_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .ss_n       (ss_n),
    .m_start    (m_start),
    .m_tx_data  (m_tx_data),
    .m_done     (m_done),
    .m_rx_data  (m_rx_data)
  );

  always #5 clk = ~clk;

  // SPI byte-master model: done 1..3 cycles after each start.
  initial begin
    forever begin
      @(negedge clk);
      m_done = 1'b0;
      if (reset) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            m_rx_data = (rx_fixed.size() > 0) ? rx_fixed.pop_front()
                                              : 8'($urandom);
            rx_q.push_back(m_rx_data);
            m_done = 1'b1;
          end
        end else if (stray_req && !m_start) begin
          m_rx_data = 8'hEE;
          m_done = 1'b1;
          stray_req = 0;
        end
        if (m_start) begin
          tx_q.push_back(m_tx_data);
          if (!hang) cd = $urandom_range(1, 3);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_req(input bit id, input bit wr, input logic [1:0] a,
                         input logic [1:0] l, input logic [31:0] wd);
    if (id) begin
      req1_write = wr; req1_addr = a; req1_len = l; req1_wdata = wd;
      req1_valid = 1'b1;
    end else begin
      req0_write = wr; req0_addr = a; req0_len = l; req0_wdata = wd;
      req0_valid = 1'b1;
    end
  endtask

  // Issue one request and check the bytes and the response against the rules.
  task automatic run_txn(input string tag, input bit id, input bit wr,
                         input logic [1:0] a, input logic [1:0] l,
                         input logic [31:0] wd);
    bit got;
    logic [7:0] exp_b;
    logic [31:0] exp_rd;
    tx_q.delete();
    rx_q.delete();
    set_req(id, wr, a, l, wd);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    check({tag, "_ready"}, 32'(got), 32'd1);
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    check({tag, "_rsp"}, 32'(got), 32'd1);
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_nbytes"}, 32'(tx_q.size()), 32'(l) + 32'd2);
    exp_rd = '0;
    for (int b = 0; b < tx_q.size() && b <= int'(l) + 1; b++) begin
      if (b == 0)
        exp_b = {wr, 5'b0, a};
      else
        exp_b = wr ? 8'(wd >> (8 * (b - 1))) : 8'h00;
      check($sformatf("%s_tx%0d", tag, b), 32'(tx_q[b]), 32'(exp_b));
      if (!wr && b > 0 && b < rx_q.size())
        exp_rd = exp_rd | (32'(rx_q[b]) << (8 * (b - 1)));
    end
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
  endtask

  initial begin
    int order[$];
    int ids[$];
    int run;
    int min_run;
    int nruns;
    bit had_low;
    bit overlap;
    bit got;
    int cyc;

    // Reset values while reset is held.
    @(negedge clk);
    check("rst_ss_n", 32'(ss_n), 32'd1);
    check("rst_m_start", 32'(m_start), 32'd0);
    check("rst_tx", 32'(m_tx_data), 32'd0);
    check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    check("rst_rsp", {rsp_valid, rsp_id, rsp_err, 29'd0}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Simultaneous requests right after reset: req0 first, then req1.
    set_req(0, 1, 2'd0, 2'd0, 32'h0000_0012);
    set_req(1, 1, 2'd3, 2'd1, 32'h0000_3456);
    run = 0; min_run = 1000; nruns = 0; had_low = 0; overlap = 0;
    for (int i = 0; i < 400 && ids.size() < 2; i++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) overlap = 1;
      if (req0_ready) begin order.push_back(0); req0_valid = 0; end
      if (req1_ready) begin order.push_back(1); req1_valid = 0; end
      if (rsp_valid) ids.push_back(int'(rsp_id));
      if (!ss_n) begin
        if (had_low && run > 0) begin
          nruns++;
          if (run < min_run) min_run = run;
        end
        had_low = 1;
        run = 0;
      end else begin
        run++;
      end
    end
    check("arb_ngrant", 32'(order.size()), 32'd2);
    check("arb_first", (order.size() > 0) ? 32'(order[0]) : 32'hFFFF, 32'd0);
    check("arb_second", (order.size() > 1) ? 32'(order[1]) : 32'hFFFF, 32'd1);
    check("arb_overlap", 32'(overlap), 32'd0);
    check("arb_rsp_id1", (ids.size() > 1) ? 32'(ids[1]) : 32'hFFFF, 32'd1);
    check("arb_gap_seen", 32'(nruns), 32'd1);
    check("arb_gap_min", 32'(min_run >= int'(GAP)), 32'd1);
    repeat (GAP + 2) @(negedge clk);

    // Directed write and directed read.
    run_txn("wr_a55a", 0, 1, 2'd1, 2'd1, 32'h0000_A55A);
    rx_fixed.delete();
    rx_fixed.push_back(8'hCC);
    rx_fixed.push_back(8'h11);
    rx_fixed.push_back(8'h22);
    rx_fixed.push_back(8'h33);
    rx_fixed.push_back(8'h44);
    run_txn("rd_fixed", 1, 0, 2'd2, 2'd3, 32'h0);
    check("rd_fixed_val", rsp_rdata, 32'h4433_2211);

    // Randomised transactions.
    for (int t = 0; t < 10; t++) begin
      run_txn($sformatf("rnd%0d", t), 1'($urandom), 1'($urandom),
              2'($urandom), 2'($urandom), $urandom);
    end

    // Stray m_done during gap, then a read.
    run_txn("pre_stray", 0, 1, 2'd0, 2'd2, 32'h00C0_FFEE);
    stray_req = 1;
    repeat (2) @(negedge clk);
    check("stray_sent", 32'(stray_req), 32'd0);
    run_txn("post_stray", 1, 0, 2'd1, 2'd2, 32'h0);

    // Reset during byte 1 of a 4-byte write.
    repeat (GAP + 2) @(negedge clk);
    tx_q.delete();
    set_req(0, 1, 2'd0, 2'd3, 32'hDEAD_BEEF);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (req0_ready) req0_valid = 0;
      got = (tx_q.size() >= 3);
    end
    check("mid_reached_b1", 32'(got), 32'd1);
    check("mid_ss_low", 32'(ss_n), 32'd0);
    reset = 1'b1;
    #1;
    check("mid_ss_async", 32'(ss_n), 32'd1);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b0;
      if (rsp_valid) got = 1;
    end
    check("mid_no_rsp", 32'(got), 32'd0);
    run_txn("after_rst", 1, 1, 2'd3, 2'd3, 32'h0102_0304);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Slave never answers: abort after TMO cycles with an error.
    repeat (GAP + 2) @(negedge clk);
    hang = 1;
    set_req(0, 0, 2'd1, 2'd0, 32'h0);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req0_ready) req0_valid = 0;
      got = m_start;
    end
    check("tmo_start", 32'(got), 32'd1);
    cyc = 0;
    for (int i = 0; i < 100 && !ss_n; i++) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo_cycles", 32'(cyc), 32'(TMO));
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    check("tmo_rsp", 32'(got), 32'd1);
    check("tmo_err", 32'(rsp_err), 32'd1);
    check("tmo_rdata", rsp_rdata, 32'd0);
    hang = 0;
`else
    cyc = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
